// File: rtl/inc_rom_size_loader.sv
// Copies a zero-latency boot ROM into SDRAM via the controller's host write port,
// one word per handshake, exporting the count of completed words.
module inc_rom_size_loader #(
    parameter int          ROM_WORDS = 2048,
    parameter logic [23:0] BASE_ADDR = 24'h000000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [11:0] addrrom_size,
    output logic [23:0] addr,
    input  logic [15:0] dout,
    output logic [15:0] data,
    output logic        wr,
    input  logic        done,
    output logic [11:0] addrrom
);

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_WAIT   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    localparam logic [11:0] LAST_COUNT = 12'(ROM_WORDS);

    state_t      state_q, state_d;
    logic [11:0] idx_q, idx_d;
    logic [11:0] size_q, size_d;
    logic [23:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        wr_q, wr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOAD;
            idx_q   <= 12'd0;
            size_q  <= 12'd0;
            addr_q  <= BASE_ADDR;
            data_q  <= 16'd0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        size_d  = size_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_d    = wr_q;
        case (state_q)
            S_LOAD: begin
                // ROM is combinational on addrrom (== idx), so dout is valid now.
                data_d  = dout;
                addr_d  = BASE_ADDR + {12'd0, idx_q};
                wr_d    = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (done) begin
                    wr_d   = 1'b0;
                    idx_d  = idx_q + 12'd1;
                    size_d = size_q + 12'd1;
                    if (size_q + 12'd1 == LAST_COUNT) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_FINISH: begin
                wr_d = 1'b0;
            end
            default: begin
                state_d = S_LOAD;
                wr_d    = 1'b0;
            end
        endcase
    end

    assign addrrom      = idx_q;
    assign addrrom_size = size_q;
    assign addr         = addr_q;
    assign data         = data_q;
    assign wr           = wr_q;

endmodule

// File: tb/tb_inc_rom_size_loader.sv
// Bench for inc_rom_size_loader: two instances (4 words at base 0, 3 words at a
// wrapping base) driven through handshake, stall, reset and idle-done sequences.
module tb_inc_rom_size_loader;

    typedef struct {
        int unsigned k;
        logic [23:0] addr;
        logic [15:0] data;
    } wr_vec_t;

    logic        clk = 1'b0;
    logic        rst_s [2];
    logic        done_s [2];
    logic [11:0] size_s [2];
    logic [23:0] addr_s [2];
    logic [15:0] dout_s [2];
    logic [15:0] data_s [2];
    logic        wr_s [2];
    logic [11:0] addrrom_s [2];

    wr_vec_t tbl_a [4];
    wr_vec_t tbl_b [3];
    wr_vec_t sb_a [$];
    wr_vec_t sb_b [$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Boot ROM model: word k holds A000+k.
    assign dout_s[0] = 16'hA000 + {4'd0, addrrom_s[0]};
    assign dout_s[1] = 16'hA000 + {4'd0, addrrom_s[1]};

    inc_rom_size_loader #(.ROM_WORDS(4), .BASE_ADDR(24'h000000)) dut_a (
        .clk(clk), .rst(rst_s[0]), .addrrom_size(size_s[0]), .addr(addr_s[0]),
        .dout(dout_s[0]), .data(data_s[0]), .wr(wr_s[0]), .done(done_s[0]),
        .addrrom(addrrom_s[0])
    );

    inc_rom_size_loader #(.ROM_WORDS(3), .BASE_ADDR(24'hFFFFFE)) dut_b (
        .clk(clk), .rst(rst_s[1]), .addrrom_size(size_s[1]), .addr(addr_s[1]),
        .dout(dout_s[1]), .data(data_s[1]), .wr(wr_s[1]), .done(done_s[1]),
        .addrrom(addrrom_s[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_table(input int d);
        if (d == 0) begin
            sb_a.delete();
            foreach (tbl_a[i]) sb_a.push_back(tbl_a[i]);
        end else begin
            sb_b.delete();
            foreach (tbl_b[i]) sb_b.push_back(tbl_b[i]);
        end
    endtask

    task automatic wait_wr(input int d);
        int n = 0;
        while (wr_s[d] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (wr_s[d] !== 1'b1) check("wr_timeout", 32'(wr_s[d]), 32'd1);
    endtask

    task automatic expect_write(input int d);
        wr_vec_t v;
        int      qsize;
        qsize = (d == 0) ? sb_a.size() : sb_b.size();
        if (qsize == 0) begin
            check("sb_underflow", 32'd0, 32'd1);
        end else begin
            v = (d == 0) ? sb_a.pop_front() : sb_b.pop_front();
            check("wr_addr", 32'(addr_s[d]), 32'(v.addr));
            check("wr_data", 32'(data_s[d]), 32'(v.data));
            check("wr_rom_idx", 32'(addrrom_s[d]), v.k);
            check("wr_size", 32'(size_s[d]), v.k);
            $display("dut%0d write k=%0d addr=%06h data=%04h size=%0d",
                     d, v.k, addr_s[d], data_s[d], size_s[d]);
        end
    endtask

    task automatic pulse_done(input int d);
        done_s[d] = 1'b1;
        tick();
        done_s[d] = 1'b0;
    endtask

    initial begin
        tbl_a[0] = '{0, 24'h000000, 16'hA000};
        tbl_a[1] = '{1, 24'h000001, 16'hA001};
        tbl_a[2] = '{2, 24'h000002, 16'hA002};
        tbl_a[3] = '{3, 24'h000003, 16'hA003};
        tbl_b[0] = '{0, 24'hFFFFFE, 16'hA000};
        tbl_b[1] = '{1, 24'hFFFFFF, 16'hA001};
        tbl_b[2] = '{2, 24'h000000, 16'hA002};

        rst_s[0] = 1'b1; rst_s[1] = 1'b1;
        done_s[0] = 1'b0; done_s[1] = 1'b0;
        repeat (3) tick();

        check("rst_wr", 32'(wr_s[0]), 32'd0);
        check("rst_addrrom", 32'(addrrom_s[0]), 32'd0);
        check("rst_size", 32'(size_s[0]), 32'd0);
        check("rst_addr", 32'(addr_s[0]), 32'd0);
        check("rst_data", 32'(data_s[0]), 32'd0);
        check("rst_addr_b", 32'(addr_s[1]), 32'hFFFFFE);

        // Word 0: wr must rise on the very first edge after reset release.
        rst_s[0] = 1'b0;
        push_table(0);
        tick();
        check("first_wr", 32'(wr_s[0]), 32'd1);
        expect_write(0);
        repeat (2) tick();
        pulse_done(0);
        check("w0_wr_low", 32'(wr_s[0]), 32'd0);
        check("w0_size", 32'(size_s[0]), 32'd1);
        check("w0_addrrom", 32'(addrrom_s[0]), 32'd1);
        tick();
        check("w0_gap_one", 32'(wr_s[0]), 32'd1);

        // Word 1: controller stalls 50 cycles.
        expect_write(0);
        for (int i = 0; i < 50; i++) begin
            tick();
            check("stall_wr", 32'(wr_s[0]), 32'd1);
            check("stall_addr", 32'(addr_s[0]), 32'd1);
            check("stall_data", 32'(data_s[0]), 32'hA001);
            check("stall_size", 32'(size_s[0]), 32'd1);
        end
        pulse_done(0);
        check("w1_wr_low", 32'(wr_s[0]), 32'd0);
        check("w1_size", 32'(size_s[0]), 32'd2);
        tick();
        check("w1_gap_one", 32'(wr_s[0]), 32'd1);

        // Word 2: done held two cycles; second cycle lands in LOAD and is ignored.
        expect_write(0);
        done_s[0] = 1'b1;
        tick();
        check("dd_wr_low", 32'(wr_s[0]), 32'd0);
        check("dd_size", 32'(size_s[0]), 32'd3);
        tick();
        done_s[0] = 1'b0;
        check("dd_wr_rise", 32'(wr_s[0]), 32'd1);
        check("dd_size_once", 32'(size_s[0]), 32'd3);

        // Word 3 then FINISH, with done pulses that must change nothing.
        expect_write(0);
        repeat (2) tick();
        pulse_done(0);
        check("fin_wr", 32'(wr_s[0]), 32'd0);
        check("fin_size", 32'(size_s[0]), 32'd4);
        check("fin_addrrom", 32'(addrrom_s[0]), 32'd4);
        for (int i = 0; i < 6; i++) begin
            done_s[0] = (i % 2 == 0);
            tick();
            check("fin_hold_wr", 32'(wr_s[0]), 32'd0);
            check("fin_hold_size", 32'(size_s[0]), 32'd4);
            check("fin_hold_addr", 32'(addr_s[0]), 32'd3);
            check("fin_hold_data", 32'(data_s[0]), 32'hA003);
            check("fin_hold_addrrom", 32'(addrrom_s[0]), 32'd4);
        end
        done_s[0] = 1'b0;
        check("sb_a_empty", 32'(sb_a.size()), 32'd0);

        // Restart, then reset (together with done) while waiting on word 2.
        rst_s[0] = 1'b1;
        tick();
        rst_s[0] = 1'b0;
        push_table(0);
        for (int w = 0; w < 2; w++) begin
            wait_wr(0);
            expect_write(0);
            pulse_done(0);
        end
        wait_wr(0);
        expect_write(0);
        rst_s[0] = 1'b1;
        done_s[0] = 1'b1;
        tick();
        check("mid_rst_wr", 32'(wr_s[0]), 32'd0);
        check("mid_rst_addrrom", 32'(addrrom_s[0]), 32'd0);
        check("mid_rst_size", 32'(size_s[0]), 32'd0);
        check("mid_rst_addr", 32'(addr_s[0]), 32'd0);
        rst_s[0] = 1'b0;
        done_s[0] = 1'b0;
        push_table(0);
        tick();
        check("restart_wr", 32'(wr_s[0]), 32'd1);
        expect_write(0);

        // Second instance: base address wraps past 2^24.
        rst_s[1] = 1'b0;
        push_table(1);
        for (int w = 0; w < 3; w++) begin
            wait_wr(1);
            expect_write(1);
            pulse_done(1);
        end
        repeat (3) tick();
        check("b_size", 32'(size_s[1]), 32'd3);
        check("b_wr_idle", 32'(wr_s[1]), 32'd0);
        check("sb_b_empty", 32'(sb_b.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inc_rom_size_loader.md
Name: inc_rom_size_loader

Overview:
Sequencer that copies the contents of a combinational boot ROM into SDRAM through the SDRAM controller's host write interface. It walks the ROM addresses one word at a time and issues one host write per word. Each write is held until the controller signals done. The running count of completed words is exported as addrrom_size.

Parameters:
ROM_WORDS, 2048, number of ROM words to copy; legal range 1..4095.
BASE_ADDR, 24'h000000, SDRAM word address that receives ROM word 0.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
addrrom_size  out  12  count of words whose write has completed.
addr  out  24  SDRAM host write address.
dout  in  16  ROM read data; combinational function of addrrom.
data  out  16  SDRAM host write data.
wr  out  1  host write request; level, held until done.
done  in  1  controller write-complete pulse.
addrrom  out  12  ROM read address.

Behaviour:
- All outputs are registered. Reset values: addrrom=0, addrrom_size=0, addr=BASE_ADDR, data=0, wr=0. State goes to LOAD.
- Internal word index idx is 12 bits. addrrom always equals idx.
- State LOAD:
  - wr=0.
  - At the next edge: data<=dout (ROM word at idx), addr<=BASE_ADDR+idx (24-bit, wraps modulo 2^24), wr<=1, go to WAIT.
- State WAIT:
  - wr, addr and data are held stable.
  - done=0: stay in WAIT; there is no timeout.
  - done=1: at that edge wr<=0, idx<=idx+1, addrrom_size<=addrrom_size+1.
  - If addrrom_size+1==ROM_WORDS, go to FINISH; otherwise go to LOAD.
- State FINISH:
  - Terminal state: wr=0, addrrom_size==ROM_WORDS.
  - All outputs are frozen until the next rst.
- done is ignored in LOAD and FINISH. A done pulse longer than one cycle counts only once, because wr is already 0 in the following LOAD cycle.
- Timing:
  - wr first rises on the first edge after rst deasserts.
  - Per-word cost is 2 cycles plus the controller latency. This comes from one LOAD cycle with wr=0 between writes, which guarantees a visible wr low gap.
- rst mid-transfer: on the next edge wr drops, all registers return to reset values and the copy restarts from word 0. A write already presented to the controller is abandoned.
- rst and done in the same cycle: rst wins.
- The ROM has zero latency, so dout is sampled in the LOAD cycle in which addrrom already equals idx.

Test Plan:
- Reset, then ROM_WORDS=4 with ROM word k=16'hA000+k and done pulsed 3 cycles after each wr rise -> four writes with (addr,data) = (0,A000), (1,A001), (2,A002), (3,A003). wr is low for exactly one cycle between writes. addrrom_size ends at 4 and wr stays 0 thereafter.
- BASE_ADDR=24'hFFFFFE, ROM_WORDS=3 -> addr sequence FFFFFE, FFFFFF, 000000 (wraps).
- Hold done low for 50 cycles during word 1 -> wr, addr and data stay constant; addrrom_size stays 1; the transfer resumes on done.
- done held high for 2 consecutive cycles -> exactly one increment of addrrom_size; the next wr rises only after the LOAD cycle.
- Assert rst while in WAIT on word 2 -> the next edge gives wr=0, addrrom=0 and addrrom_size=0. After release, the first write is word 0 again.
- done pulses in LOAD and in FINISH -> no change to counters or outputs.
